// File: rtl/ticker_timer.sv
// Bus-mapped tick timer: prescaler, free-running WIDTH-bit counter, N_CMP sticky compare flags.
// Define TICKER_IRQ_EN to build the IRQ_EN mask register and the registered irq output.
module ticker_timer #(
  parameter int          WIDTH        = 32,
  parameter int          N_CMP        = 2,
  parameter logic [31:0] PRESCALE_RST = 32'd9999,
  parameter logic        EN_RST       = 1'b1
) (
  input  logic        clk_bus,
  input  logic        rst_n,
  input  logic [7:0]  bus_address,
  input  logic [31:0] bus_data_i,
  input  logic        bus_read,
  input  logic        bus_write,
  output logic [31:0] bus_data_o,
  output logic        irq
);

  localparam logic [5:0] A_COUNT    = 6'h00;
  localparam logic [5:0] A_CTRL     = 6'h01;
  localparam logic [5:0] A_PRESCALE = 6'h02;
  localparam logic [5:0] A_STATUS   = 6'h03;
  localparam logic [5:0] A_IRQ_EN   = 6'h04;
  localparam logic [5:0] A_CMP0     = 6'h08;

  logic [WIDTH-1:0] r_count;
  logic [31:0]      r_presc;
  logic [31:0]      r_prescale;
  logic             r_en;
  logic [N_CMP-1:0] r_status;
  logic [WIDTH-1:0] r_cmp [N_CMP];

  logic [5:0]       w_reg;
  logic             w_wr_count;
  logic             w_wr_ctrl;
  logic             w_wr_prescale;
  logic             w_wr_status;
  logic             w_tick;
  logic [WIDTH-1:0] w_count_inc;
  logic [N_CMP-1:0] w_hit;
  logic [N_CMP-1:0] w_clr;
  logic [N_CMP-1:0] w_irq_en;
  logic [31:0]      w_rdata;
  logic             w_unused_addr;

  assign w_reg         = bus_address[7:2];
  assign w_unused_addr = ^bus_address[1:0];
  assign w_wr_count    = bus_write && (w_reg == A_COUNT);
  assign w_wr_ctrl     = bus_write && (w_reg == A_CTRL);
  assign w_wr_prescale = bus_write && (w_reg == A_PRESCALE);
  assign w_wr_status   = bus_write && (w_reg == A_STATUS);

  assign w_tick      = r_en && (r_presc == r_prescale);
  assign w_count_inc = r_count + WIDTH'(1);
  assign w_clr       = w_wr_status ? bus_data_i[N_CMP-1:0] : '0;

  // A COUNT write replaces the tick, so its loaded value never raises a flag.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < N_CMP; i++) begin
      w_hit[i] = w_tick && !w_wr_count && (w_count_inc == r_cmp[i]);
    end
  end

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      r_count    <= '0;
      r_presc    <= '0;
      r_en       <= EN_RST;
      r_prescale <= PRESCALE_RST;
      r_status   <= '0;
      for (int i = 0; i < N_CMP; i++) begin
        r_cmp[i] <= '1;
      end
    end else begin
      if (w_wr_count || w_wr_prescale || w_wr_ctrl || w_tick) begin
        r_presc <= '0;
      end else if (r_en) begin
        r_presc <= r_presc + 32'd1;
      end

      if (w_wr_count) begin
        r_count <= bus_data_i[WIDTH-1:0];
      end else if (w_tick) begin
        r_count <= w_count_inc;
      end

      if (w_wr_ctrl) begin
        r_en <= bus_data_i[0];
      end
      if (w_wr_prescale) begin
        r_prescale <= bus_data_i;
      end

      // Set beats clear when both land on the same edge.
      r_status <= (r_status & ~w_clr) | w_hit;

      for (int i = 0; i < N_CMP; i++) begin
        if (bus_write && (w_reg == A_CMP0 + 6'(i))) begin
          r_cmp[i] <= bus_data_i[WIDTH-1:0];
        end
      end
    end
  end

`ifdef TICKER_IRQ_EN
  logic [N_CMP-1:0] r_irq_en;
  logic             r_irq;
  logic             w_wr_irq_en;

  assign w_wr_irq_en = bus_write && (w_reg == A_IRQ_EN);

  always_ff @(posedge clk_bus) begin
    if (!rst_n) begin
      r_irq_en <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_irq_en) begin
        r_irq_en <= bus_data_i[N_CMP-1:0];
      end
      r_irq <= |(r_status & r_irq_en);
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = '0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    w_rdata = '0;
    if (bus_read) begin
      case (w_reg)
        A_COUNT:    w_rdata[WIDTH-1:0] = r_count;
        A_CTRL:     w_rdata[0]         = r_en;
        A_PRESCALE: w_rdata            = r_prescale;
        A_STATUS:   w_rdata[N_CMP-1:0] = r_status;
        A_IRQ_EN:   w_rdata[N_CMP-1:0] = w_irq_en;
        default: begin
          for (int i = 0; i < N_CMP; i++) begin
            if (w_reg == A_CMP0 + 6'(i)) begin
              w_rdata[WIDTH-1:0] = r_cmp[i];
            end
          end
        end
      endcase
    end
  end

  assign bus_data_o = w_rdata;

endmodule

// File: tb/tb_ticker_timer.sv
// Self-checking bench for ticker_timer: directed scenarios plus random bus traffic,
// checked by a read monitor against a cycle-level reference model.
module tb_ticker_timer;

  localparam int WIDTH = 32;
  localparam int N_CMP = 2;
  localparam longint MOD = longint'(1) << WIDTH;
`ifdef TICKER_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  // clock/reset block
  logic        clk_bus = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bus_address = '0;
  logic [31:0] bus_data_i = '0;
  logic        bus_read = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_data_o;
  logic        irq;

  always #5 clk_bus = ~clk_bus;

  ticker_timer #(.WIDTH(WIDTH), .N_CMP(N_CMP)) dut (
    .clk_bus(clk_bus), .rst_n(rst_n), .bus_address(bus_address),
    .bus_data_i(bus_data_i), .bus_read(bus_read), .bus_write(bus_write),
    .bus_data_o(bus_data_o), .irq(irq)
  );

  // Reference model: prescaling expressed as "enabled cycles since last clear".
  longint           m_count;
  longint           m_phase;
  longint           m_prescale;
  bit               m_en;
  logic [N_CMP-1:0] m_status;
  logic [N_CMP-1:0] m_irqen;
  longint           m_cmp [N_CMP];
  bit               m_irq;

  logic [32:0] exp_q[$];
  logic [7:0]  addr_q[$];
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic model_step();
    bit               tick;
    longint           newc;
    logic [N_CMP-1:0] hits;
    logic [5:0]       a;
    bit               wc, wctl, wp, ws;
    if (!rst_n) begin
      m_count = 0; m_phase = 0; m_prescale = 9999; m_en = 1'b1;
      m_status = '0; m_irqen = '0; m_irq = 1'b0;
      for (int i = 0; i < N_CMP; i++) m_cmp[i] = MOD - 1;
      return;
    end
    a    = bus_address[7:2];
    wc   = bus_write && (a == 6'h00);
    wctl = bus_write && (a == 6'h01);
    wp   = bus_write && (a == 6'h02);
    ws   = bus_write && (a == 6'h03);
    tick = m_en && ((m_phase % (m_prescale + 1)) == m_prescale);
    newc = (m_count + 1) % MOD;
    hits = '0;
    for (int i = 0; i < N_CMP; i++)
      if (tick && !wc && newc == m_cmp[i]) hits[i] = 1'b1;
    m_irq = IRQ_BUILD && (|(m_status & m_irqen));
    m_status = (m_status & ~(ws ? bus_data_i[N_CMP-1:0] : '0)) | hits;
    if (wc || wctl || wp) m_phase = 0;
    else if (m_en) m_phase = m_phase + 1;
    if (wc) m_count = longint'(bus_data_i) % MOD;
    else if (tick) m_count = newc;
    if (wctl) m_en = bus_data_i[0];
    if (wp) m_prescale = longint'(bus_data_i);
    if (IRQ_BUILD && bus_write && a == 6'h04) m_irqen = bus_data_i[N_CMP-1:0];
    for (int i = 0; i < N_CMP; i++)
      if (bus_write && a == 6'h08 + 6'(i)) m_cmp[i] = longint'(bus_data_i) % MOD;
  endtask

  function automatic logic [31:0] m_read(input logic [7:0] addr);
    logic [5:0] a;
    a = addr[7:2];
    case (a)
      6'h00: return 32'(m_count);
      6'h01: return {31'd0, m_en};
      6'h02: return 32'(m_prescale);
      6'h03: return 32'(m_status);
      6'h04: return IRQ_BUILD ? 32'(m_irqen) : 32'd0;
      default: begin
        for (int i = 0; i < N_CMP; i++)
          if (a == 6'h08 + 6'(i)) return 32'(m_cmp[i]);
        return 32'd0;
      end
    endcase
  endfunction

  // driver tasks: inputs change #1 after posedge; model advances on each posedge
  task automatic cycle();
    @(posedge clk_bus);
    model_step();
    #1;
    bus_read = 1'b0;
    bus_write = 1'b0;
  endtask

  task automatic op(input bit w, input bit r, input logic [7:0] a, input logic [31:0] d);
    bus_address = a; bus_data_i = d; bus_write = w; bus_read = r;
    if (r) begin
      exp_q.push_back({m_irq, m_read(a)});
      addr_q.push_back(a);
    end
    cycle();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    op(1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [7:0] a);
    op(1'b0, 1'b1, a, 32'd0);
  endtask

  task automatic rd_const(input logic [7:0] a, input logic [31:0] v, input bit i);
    bus_address = a; bus_read = 1'b1;
    exp_q.push_back({i, v});
    addr_q.push_back(a);
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) op(1'b0, 1'b0, 8'h00, 32'd0);
  endtask

  // scoreboard monitor: compares every presented read against the queue head
  always @(negedge clk_bus) begin
    if (bus_read) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL rd_unexpected addr=0x%02h got data=0x%08h irq=%0b want no read", bus_address, bus_data_o, irq);
      end else begin
        logic [32:0] e;
        logic [7:0]  a;
        e = exp_q.pop_front();
        a = addr_q.pop_front();
        if ({irq, bus_data_o} === e) n_pass++;
        else $display("FAIL rd addr=0x%02h got data=0x%08h irq=%0b want data=0x%08h irq=%0b",
                      a, bus_data_o, irq, e[31:0], e[32]);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] addr_tab [12];
    int         k;
    bit         found;
    addr_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h20, 8'h24, 8'h28, 8'h40, 8'h01, 8'h22};

    // reset: two edges low, then reset values (constants)
    @(posedge clk_bus); #1;
    idle(2);
    rst_n = 1'b1;
    rd_const(8'h00, 32'd0, 1'b0);
    rd_const(8'h04, 32'd1, 1'b0);
    rd_const(8'h08, 32'd9999, 1'b0);
    rd_const(8'h0C, 32'd0, 1'b0);
    rd_const(8'h20, 32'hFFFF_FFFF, 1'b0);
    rd_const(8'h10, 32'd0, 1'b0);

    // prescale 3: 40 cycles -> 10 ticks; then every-cycle ticking
    wr(8'h08, 32'd3);
    wr(8'h00, 32'd0);
    idle(40);
    rd_const(8'h00, 32'd10, 1'b0);
    wr(8'h08, 32'd0);
    repeat (3) rd(8'h00);

    // wrap through all-ones with CMP0 out of the way
    wr(8'h20, 32'h80);
    wr(8'h00, 32'hFFFF_FFFE);
    repeat (4) rd(8'h00);
    rd(8'h0C);

    // compare hit, irq, W1C, and set-beats-clear
    wr(8'h20, 32'd5);
    wr(8'h10, 32'd1);
    wr(8'h0C, 32'h3);
    wr(8'h00, 32'd0);
    repeat (8) rd(8'h0C);
    wr(8'h0C, 32'd1);
    repeat (3) rd(8'h0C);
    wr(8'h00, 32'd4);
    idle(1);
    rd(8'h0C);
    wr(8'h00, 32'd4);
    wr(8'h0C, 32'd1);
    rd(8'h0C);
    rd(8'h0C);

    // hold with EN=0, then load on a tick cycle
    wr(8'h04, 32'd0);
    rd(8'h00);
    idle(100);
    rd(8'h00);
    rd(8'h04);
    wr(8'h04, 32'd1);
    wr(8'h00, 32'h1234);
    rd_const(8'h00, 32'h1234, m_irq);
    rd(8'h00);

    // undefined addresses ignore writes and read 0
    wr(8'h14, 32'hDEAD_BEEF);
    wr(8'h40, 32'h1234_5678);
    rd(8'h14);
    rd(8'h40);
    rd(8'h28);

    // reset in mid-count with a pending flag/irq
    wr(8'h0C, 32'h3);
    wr(8'h08, 32'd3);
    wr(8'h20, 32'd7);
    wr(8'h10, 32'd1);
    wr(8'h00, 32'd6);
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      if (m_count == 7 && m_irq == IRQ_BUILD && m_status[0]) found = 1'b1;
      else idle(1);
      k++;
    end
    n_checks++;
    if (found) n_pass++;
    else $display("FAIL mid_reset_setup got count=%0d irq=%0b want count=7 irq=%0b", m_count, m_irq, IRQ_BUILD);
    rd(8'h0C);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    rd_const(8'h00, 32'd0, 1'b0);
    rd_const(8'h0C, 32'd0, 1'b0);
    rd_const(8'h08, 32'd9999, 1'b0);

    // random bus traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      a = addr_tab[$urandom_range(0, 11)];
      case ($urandom_range(0, 9))
        0: wr(8'h00, $urandom_range(0, 40));
        1: wr(8'h04, {31'd0, $urandom_range(0, 3) != 0});
        2: wr(8'h08, $urandom_range(0, 3));
        3: wr(8'h0C, $urandom_range(0, 3));
        4: wr(8'h10, $urandom_range(0, 3));
        5: wr(8'h20 + 8'($urandom_range(0, N_CMP - 1) * 4), $urandom_range(0, 40));
        6: wr(a, $urandom);
        7, 8: rd(a);
        default: op(1'b1, 1'b1, a, $urandom_range(0, 40));
      endcase
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) rd(8'h0C);
    end

    idle(2);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drain got %0d pending want 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
